mem_stage_lsu: RTL and testbench
================================

# mem_stage_lsu

Memory-stage load/store unit of the 5-stage RISC-V pipeline, sitting between the EX/MEM register and the MEM/WB register. It takes the ALU-computed address and store data of the instruction in MEM, runs a request/ready transaction on the data-memory bus, aligns and extends load data, and drives the load result into the MEM/WB register's `Data_R_in`. The pipeline stalls while a transaction is outstanding.

## Interface
- `WIDTH`, 32, datapath width; only 32 is supported.

- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; asserted when 0.
- `mem_read_mem` in 1: the instruction in MEM is a load.
- `mem_write_mem` in 1: the instruction in MEM is a store.
- `funct3_mem` in 3: access width/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `addr_in` in WIDTH: byte address (ALU result).
- `store_data_in` in WIDTH: rs2 value.
- `dmem_req` out 1: bus request, registered.
- `dmem_we` out 1: 1 = write.
- `dmem_addr` out WIDTH: word-aligned address (`addr_in[31:2]`, `2'b00`).
- `dmem_wdata` out WIDTH: lane-replicated store data.
- `dmem_wstrb` out 4: byte enables.
- `dmem_rdata` in WIDTH: read data, valid while `dmem_ready`=1.
- `dmem_ready` in 1: transaction complete.
- `Data_R_out` out WIDTH: aligned/extended load result, registered; feeds MEM/WB `Data_R_in`.
- `stall_mem` out 1: combinational; freezes PC, IF/ID, ID/EX and EX/MEM.
- `misaligned` out 1: combinational; misaligned access flag to trap logic.

## Operation
**Access and alignment**
- Access = `mem_read_mem` | `mem_write_mem`. If both are set, the access is a write.
- Misaligned conditions:
  - word (010, and the unused codes 011/110/111, which are treated as word) with `addr_in[1:0]`≠0;
  - half (001/101) with `addr_in[0]`=1.

**FSM states: IDLE, BUSY, DONE**
- IDLE
  - No access: `stall_mem`=0 and nothing changes.
  - Misaligned access: `misaligned`=1, `stall_mem`=0, no bus request, and `Data_R_out` holds.
  - Aligned access: `stall_mem`=1. At the clock edge, register `dmem_req`=1 along with `dmem_we`, `dmem_addr`, `dmem_wdata` and `dmem_wstrb`, then go to BUSY.
- BUSY
  - `dmem_req` stays 1 and the bus outputs are held stable; `stall_mem`=1.
  - On an edge with `dmem_ready`=1:
    - `dmem_req` goes to 0 and `dmem_we` to 0;
    - for a load, `Data_R_out` captures the extracted data;
    - for a store, `Data_R_out` holds;
    - go to DONE.
- DONE
  - `stall_mem`=0 so the pipeline advances this cycle, and MEM/WB samples `Data_R_out`.
  - The inputs are ignored, which prevents a re-issue of the same instruction.
  - Unconditionally go to IDLE.

**Store formatting**
- SB: `wdata` = `{4{byte}}`, `wstrb` = 0001<<`addr[1:0]`.
- SH: `wdata` = `{2{half}}`, `wstrb` = 0011<<`addr[1:0]`.
- SW: `wstrb` = 1111.
- For loads, `wstrb` = 0000.

**Load extraction**
- `shifted` = `dmem_rdata` >> (8·`addr[1:0]`), where `addr` is the registered copy.
- LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes through.

**Reset (`reset`=0)**
- State goes to IDLE.
- `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata`, `dmem_wstrb` and `Data_R_out` all go to 0.
- `stall_mem`=0 and `misaligned`=0 regardless of the inputs.
- A request abandoned by a reset mid-BUSY is dropped; the bus must tolerate `dmem_req` falling without `dmem_ready`.

## Timing
- Minimum access occupancy is 3 cycles (IDLE → BUSY with `dmem_ready` in the first BUSY cycle → DONE), i.e. 2 stall cycles.
- With N cycles of ready latency, total stall = N+1 cycles.
- `dmem_req` rises one cycle after the access is seen in IDLE and falls on the edge where `dmem_ready`=1 is sampled.
- `dmem_ready` is ignored outside BUSY.
- `Data_R_out` is valid from the cycle after `dmem_ready` until the next load completes.
- Back-to-back accesses: each new access is seen in the IDLE cycle following DONE; there is no bubble beyond that.
- Non-memory instructions pass with zero stall.

## Test plan
- LW, `addr_in`=0x100, memory word 0x8899AABC, ready after 1 cycle → `dmem_addr`=0x100, `wstrb`=0000, `Data_R_out`=0x8899AABC, `stall_mem` high for exactly 2 cycles.
- LB / LBU at 0x103 with word 0x80FF1234 → LB gives 0xFFFFFF80 and LBU gives 0x00000080; LH at 0x102 gives 0xFFFF80FF.
- SB at 0x101 with `store_data_in`=0x000000A5 → `wdata`=0xA5A5A5A5, `wstrb`=0010, `dmem_we`=1. SH at 0x102 with data 0x1234 → `wstrb`=1100. SW → `wstrb`=1111.
- Ready delayed 4 cycles → `dmem_req` and bus outputs stable for all 4 cycles, `stall_mem` high for 5 cycles, single capture.
- LW at 0x102 or SH at 0x101 → `misaligned`=1, no `dmem_req`, `stall_mem`=0, `Data_R_out` unchanged.
- Drive `reset` low while in BUSY → `dmem_req`=0 and `Data_R_out`=0 immediately; after release, the state is IDLE and the next LW completes normally.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit of the 5-stage pipeline.
// Takes the MEM-stage address and store data, runs one request/ready
// transaction on the data bus, then aligns and extends the load data
// into Data_R_out, which feeds the MEM/WB register.
//
// Ports:
//   clk, reset                   clock, async active-low reset
//   mem_read_mem, mem_write_mem  instruction in MEM is a load / store
//   funct3_mem                   access width and sign
//   addr_in, store_data_in       byte address, rs2 value
//   dmem_req/we/addr/wdata/wstrb registered bus request
//   dmem_rdata, dmem_ready       bus response
//   Data_R_out                   registered load result
//   stall_mem                    freezes the upstream pipeline registers
//   misaligned                   misaligned-access flag to trap logic
//
// state | meaning
// IDLE  | waiting for an access; issues the request on the next edge
// BUSY  | request outstanding, bus outputs held until dmem_ready
// DONE  | result ready, pipeline advances; inputs ignored for one cycle
module mem_stage_lsu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_read_mem,
  input  logic             mem_write_mem,
  input  logic [2:0]       funct3_mem,
  input  logic [WIDTH-1:0] addr_in,
  input  logic [WIDTH-1:0] store_data_in,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  output logic [3:0]       dmem_wstrb,
  input  logic [WIDTH-1:0] dmem_rdata,
  input  logic             dmem_ready,
  output logic [WIDTH-1:0] Data_R_out,
  output logic             stall_mem,
  output logic             misaligned
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             access;
  logic             mis_cond;
  logic             issue;
  logic [1:0]       addr_lo;
  logic [2:0]       funct3_q;
  logic [WIDTH-1:0] wdata_fmt;
  logic [3:0]       wstrb_fmt;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] load_val;

  assign access = mem_read_mem | mem_write_mem;

  // Codes 011/110/111 fall into the word case.
  always_comb begin
    case (funct3_mem[1:0])
      2'b00:   mis_cond = 1'b0;
      2'b01:   mis_cond = addr_in[0];
      default: mis_cond = |addr_in[1:0];
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (access && !mis_cond) state_nxt = BUSY;
      BUSY:    if (dmem_ready) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Flags are gated by reset so they read 0 while reset is held,
  // whatever the instruction inputs show.
  always_comb begin
    stall_mem  = 1'b0;
    misaligned = 1'b0;
    issue      = 1'b0;
    if (reset) begin
      case (state)
        IDLE: begin
          if (access) begin
            if (mis_cond) begin
              misaligned = 1'b1;
            end else begin
              stall_mem = 1'b1;
              issue     = 1'b1;
            end
          end
        end
        BUSY:    stall_mem = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    wdata_fmt = store_data_in;
    wstrb_fmt = 4'b1111;
    case (funct3_mem[1:0])
      2'b00: begin
        wdata_fmt = {4{store_data_in[7:0]}};
        wstrb_fmt = 4'b0001 << addr_in[1:0];
      end
      2'b01: begin
        wdata_fmt = {2{store_data_in[15:0]}};
        wstrb_fmt = 4'b0011 << addr_in[1:0];
      end
      default: ;
    endcase
    if (!mem_write_mem) wstrb_fmt = 4'b0000;
  end

  assign shifted = dmem_rdata >> {addr_lo, 3'b000};

  always_comb begin
    case (funct3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'd0, shifted[7:0]};
      3'b101:  load_val = {16'd0, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  // dmem_we is still set on the completing edge, so it tells a store
  // from a load without a separate flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_wstrb <= 4'b0000;
      Data_R_out <= '0;
      addr_lo    <= 2'b00;
      funct3_q   <= 3'b000;
    end else if (issue) begin
      dmem_req   <= 1'b1;
      dmem_we    <= mem_write_mem;
      dmem_addr  <= {addr_in[WIDTH-1:2], 2'b00};
      dmem_wdata <= wdata_fmt;
      dmem_wstrb <= wstrb_fmt;
      addr_lo    <= addr_in[1:0];
      funct3_q   <= funct3_mem;
    end else if (state == BUSY && dmem_ready) begin
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
      if (!dmem_we) Data_R_out <= load_val;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: loads, stores, ready latency,
// misaligned accesses and reset during an outstanding request.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_mem;
  logic        mem_write_mem;
  logic [2:0]  funct3_mem;
  logic [31:0] addr_in;
  logic [31:0] store_data_in;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic [31:0] Data_R_out;
  logic        stall_mem;
  logic        misaligned;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_dr   = 32'h0;

  mem_stage_lsu #(.WIDTH(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_read_mem  (mem_read_mem),
    .mem_write_mem (mem_write_mem),
    .funct3_mem    (funct3_mem),
    .addr_in       (addr_in),
    .store_data_in (store_data_in),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_wstrb    (dmem_wstrb),
    .dmem_rdata    (dmem_rdata),
    .dmem_ready    (dmem_ready),
    .Data_R_out    (Data_R_out),
    .stall_mem     (stall_mem),
    .misaligned    (misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    mem_read_mem  = 1'b0;
    mem_write_mem = 1'b0;
    funct3_mem    = 3'b000;
    addr_in       = 32'h0;
    store_data_in = 32'h0;
  endtask

  // Entered just after a negedge with the DUT in IDLE; returns just after
  // the negedge of the following IDLE cycle with inputs cleared.
  task automatic run_access(input string tag, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] sd, input logic [31:0] word,
                            input int lat, input logic [3:0] exp_strb,
                            input logic [31:0] exp_wdata, input logic [31:0] exp_load);
    int stalls;
    stalls        = 0;
    mem_read_mem  = rd;
    mem_write_mem = wr;
    funct3_mem    = f3;
    addr_in       = a;
    store_data_in = sd;
    dmem_ready    = 1'b0;
    dmem_rdata    = 32'hBAD0BAD0;
    #1;
    if (stall_mem) stalls++;
    chk({tag, "_mis"}, {31'd0, misaligned}, 32'd0);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == lat) begin
        dmem_ready = 1'b1;
        dmem_rdata = word;
      end
      #1;
      if (stall_mem) stalls++;
      chk({tag, "_req"},   {31'd0, dmem_req}, 32'd1);
      chk({tag, "_we"},    {31'd0, dmem_we}, {31'd0, wr});
      chk({tag, "_addr"},  dmem_addr, {a[31:2], 2'b00});
      chk({tag, "_wstrb"}, {28'd0, dmem_wstrb}, {28'd0, exp_strb});
      if (wr) chk({tag, "_wdata"}, dmem_wdata, exp_wdata);
      chk({tag, "_hold"},  Data_R_out, exp_dr);
    end
    @(negedge clk);
    dmem_ready = 1'b0;
    dmem_rdata = 32'hBAD0BAD0;
    #1;
    if (rd && !wr) exp_dr = exp_load;
    chk({tag, "_done_stall"}, {31'd0, stall_mem}, 32'd0);
    chk({tag, "_done_req"},   {31'd0, dmem_req}, 32'd0);
    chk({tag, "_done_we"},    {31'd0, dmem_we}, 32'd0);
    chk({tag, "_data"},       Data_R_out, exp_dr);
    chk({tag, "_stalls"},     stalls, lat + 1);
    @(negedge clk);
    clear_inputs();
    #1;
    chk({tag, "_no_reissue"}, {31'd0, dmem_req}, 32'd0);
  endtask

  task automatic run_misaligned(input string tag, input logic rd, input logic wr,
                                input logic [2:0] f3, input logic [31:0] a);
    mem_read_mem  = rd;
    mem_write_mem = wr;
    funct3_mem    = f3;
    addr_in       = a;
    store_data_in = 32'h5A5A5A5A;
    #1;
    chk({tag, "_mis"},   {31'd0, misaligned}, 32'd1);
    chk({tag, "_stall"}, {31'd0, stall_mem}, 32'd0);
    @(negedge clk);
    #1;
    chk({tag, "_req"},  {31'd0, dmem_req}, 32'd0);
    chk({tag, "_data"}, Data_R_out, exp_dr);
    clear_inputs();
  endtask

  initial begin
    reset         = 1'b0;
    dmem_ready    = 1'b0;
    dmem_rdata    = 32'h0;
    mem_read_mem  = 1'b1;
    mem_write_mem = 1'b0;
    funct3_mem    = 3'b010;
    addr_in       = 32'h102;
    store_data_in = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req",   {31'd0, dmem_req}, 32'd0);
    chk("rst_we",    {31'd0, dmem_we}, 32'd0);
    chk("rst_wstrb", {28'd0, dmem_wstrb}, 32'd0);
    chk("rst_data",  Data_R_out, 32'd0);
    chk("rst_stall", {31'd0, stall_mem}, 32'd0);
    chk("rst_mis",   {31'd0, misaligned}, 32'd0);
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Loads
    run_access("lw",   1, 0, 3'b010, 32'h100, 32'h0, 32'h8899AABC, 1, 4'b0000, 32'h0, 32'h8899AABC);
    run_access("lb",   1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 1, 4'b0000, 32'h0, 32'hFFFFFF80);
    run_access("lbu",  1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 1, 4'b0000, 32'h0, 32'h00000080);
    run_access("lh",   1, 0, 3'b001, 32'h102, 32'h0, 32'h80FF1234, 1, 4'b0000, 32'h0, 32'hFFFF80FF);
    run_access("lhu",  1, 0, 3'b101, 32'h102, 32'h0, 32'h80FF1234, 1, 4'b0000, 32'h0, 32'h000080FF);
    run_access("lb1",  1, 0, 3'b000, 32'h101, 32'h0, 32'h80FF1234, 1, 4'b0000, 32'h0, 32'h00000012);

    // Stores (Data_R_out holds the last load value)
    run_access("sb",   0, 1, 3'b000, 32'h101, 32'h000000A5, 32'h0, 1, 4'b0010, 32'hA5A5A5A5, 32'h0);
    run_access("sh",   0, 1, 3'b001, 32'h102, 32'h00001234, 32'h0, 1, 4'b1100, 32'h12341234, 32'h0);
    run_access("sw",   0, 1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 1, 4'b1111, 32'hDEADBEEF, 32'h0);
    run_access("rdwr", 1, 1, 3'b010, 32'h10C, 32'h01020304, 32'h77777777, 2, 4'b1111, 32'h01020304, 32'h0);

    // Slow ready
    run_access("lw4",  1, 0, 3'b010, 32'h200, 32'h0, 32'h11223344, 4, 4'b0000, 32'h0, 32'h11223344);

    // Misaligned
    run_misaligned("mis_lw",  1, 0, 3'b010, 32'h102);
    run_misaligned("mis_sh",  0, 1, 3'b001, 32'h101);
    run_misaligned("mis_lh",  1, 0, 3'b001, 32'h103);
    run_misaligned("mis_011", 1, 0, 3'b011, 32'h101);

    // Reset while BUSY
    mem_read_mem = 1'b1;
    funct3_mem   = 3'b010;
    addr_in      = 32'h300;
    dmem_ready   = 1'b0;
    @(negedge clk);
    #1;
    chk("busy_req", {31'd0, dmem_req}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    exp_dr = 32'h0;
    chk("rbusy_req",   {31'd0, dmem_req}, 32'd0);
    chk("rbusy_data",  Data_R_out, 32'd0);
    chk("rbusy_stall", {31'd0, stall_mem}, 32'd0);
    chk("rbusy_mis",   {31'd0, misaligned}, 32'd0);
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_access("lw_post", 1, 0, 3'b010, 32'h300, 32'h0, 32'hCAFEF00D, 2, 4'b0000, 32'h0, 32'hCAFEF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
